// File: rtl/inc_param_if.sv
// Request/grant bundle between peripheral request lines, the CPU and inc_param.
// The priority table is carried on prio because "priority" is a reserved word.
interface inc_param_if #(
  parameter int N_REQ = 8,
  parameter int PRI_W = 3
);
  localparam int ID_W = $clog2(N_REQ);

  logic                     start;
  logic [1:0]               mode;
  logic [N_REQ-1:0]         inp;
  logic [N_REQ*PRI_W-1:0]   prio;
  logic [N_REQ-1:0]         mask;
  logic                     eoi;
  logic [N_REQ-1:0]         out;
  logic                     irq;
  logic [ID_W-1:0]          irq_id;
  logic [ID_W-1:0]          poll_state;

  modport master (
    output start, mode, inp, prio, mask, eoi,
    input  out, irq, irq_id, poll_state
  );

  modport slave (
    input  start, mode, inp, prio, mask, eoi,
    output out, irq, irq_id, poll_state
  );
endinterface

// File: rtl/inc_param.sv
// N-channel interrupt controller: priority, polling or round-robin arbitration
// with per-channel mask, EOI release and an encoded grant id.
module inc_param #(
  parameter int N_REQ = 8,
  parameter int PRI_W = 3
) (
  input logic        clk,
  input logic        rst,
  inc_param_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_EXT   = (ID_W + 1)'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t                   state_q, state_d;
  logic [N_REQ*PRI_W-1:0]   pri_q, pri_d;
  logic [N_REQ-1:0]         mask_q, mask_d;
  logic [N_REQ-1:0]         out_q, out_d;
  logic                     irq_q, irq_d;
  logic [ID_W-1:0]          irq_id_q, irq_id_d;
  logic [ID_W-1:0]          poll_q, poll_d;
  logic [ID_W-1:0]          rr_q, rr_d;
  logic                     poll_grant_q, poll_grant_d;

  logic [N_REQ-1:0]         act;
  logic [PRI_W-1:0]         pri_f [N_REQ];
  logic                     pri_found;
  logic [ID_W-1:0]          pri_win;
  logic [PRI_W-1:0]         pri_best;
  logic                     rr_found;
  logic [ID_W-1:0]          rr_win;
  logic [ID_W:0]            rr_idx;
  logic [ID_W-1:0]          poll_next;
  logic                     win_valid;
  logic [ID_W-1:0]          win_id;

  assign act = bus.inp & ~mask_q;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pri
    assign pri_f[gi] = pri_q[gi*PRI_W +: PRI_W];
  end

  // Strict less-than keeps the lowest index on equal priority levels.
  always_comb begin
    pri_found = 1'b0;
    pri_win   = '0;
    pri_best  = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (act[i] && (!pri_found || pri_f[i] < pri_best)) begin
        pri_found = 1'b1;
        pri_best  = pri_f[i];
        pri_win   = ID_W'(i);
      end
    end
  end

  // Wrap is done by subtraction so non-power-of-2 channel counts stay in range.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = {1'b0, rr_q} + (ID_W + 1)'(k);
      if (rr_idx >= N_EXT) begin
        rr_idx = rr_idx - N_EXT;
      end
      if (!rr_found && act[rr_idx[ID_W-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[ID_W-1:0];
      end
    end
  end

  assign poll_next = (poll_q == LAST_ID) ? '0 : poll_q + 1'b1;

  always_comb begin
    unique case (bus.mode)
      2'b01: begin
        win_valid = act[poll_q];
        win_id    = poll_q;
      end
      2'b10: begin
        win_valid = rr_found;
        win_id    = rr_win;
      end
      default: begin
        win_valid = pri_found;
        win_id    = pri_win;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pri_d        = pri_q;
    mask_d       = mask_q;
    out_d        = out_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    poll_d       = poll_q;
    rr_d         = rr_q;
    poll_grant_d = poll_grant_q;

    if (bus.start) begin
      pri_d    = bus.prio;
      mask_d   = bus.mask;
      state_d  = ST_IDLE;
      out_d    = '0;
      irq_d    = 1'b0;
      irq_id_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_d         = ST_GRANT;
            out_d           = '0;
            out_d[win_id]   = 1'b1;
            irq_d           = 1'b1;
            irq_id_d        = win_id;
            poll_grant_d    = (bus.mode == 2'b01);
            if (bus.mode == 2'b10) begin
              rr_d = win_id;
            end
          end else if (bus.mode == 2'b01) begin
            poll_d = poll_next;
          end
        end
        // Release looks at the raw request, so masking a granted channel keeps it.
        ST_GRANT: begin
          if (bus.eoi || !bus.inp[irq_id_q]) begin
            state_d  = ST_RELEASE;
            out_d    = '0;
            irq_d    = 1'b0;
            irq_id_d = '0;
            if (poll_grant_q) begin
              poll_d = poll_next;
            end
          end
        end
        ST_RELEASE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pri_q        <= '0;
      mask_q       <= '0;
      out_q        <= '0;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      poll_q       <= '0;
      rr_q         <= LAST_ID;
      poll_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pri_q        <= pri_d;
      mask_q       <= mask_d;
      out_q        <= out_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      poll_q       <= poll_d;
      rr_q         <= rr_d;
      poll_grant_q <= poll_grant_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.irq        = irq_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.poll_state = poll_q;
endmodule
